// File: rtl/fetch_pkg.sv
// Shared state encoding, constants and IF/ID payload type for the instruction fetch controller.
package fetch_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_BYTES = 4;
    localparam logic [XLEN-1:0] HALT_WORD_DEFAULT = 32'h0000_000C;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
    } if_payload_t;

    // Byte address folded into the instruction memory span.
    function automatic logic [XLEN-1:0] pc_wrap(input logic [XLEN-1:0] addr,
                                                input logic [XLEN-1:0] span);
        return addr % span;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: redirect mux plus sequential advance, both wrapped to the memory span.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned     IMEM_WORDS = 1024,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            advance,
    output logic [XLEN-1:0] pc
);

    localparam logic [XLEN-1:0] PC_SPAN = XLEN'(IMEM_WORDS * WORD_BYTES);

    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc_q;

    // Redirect wins over sequential advance.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = pc_wrap(redirect_target, PC_SPAN);
        end else if (advance) begin
            pc_d = pc_wrap(pc_q + XLEN'(WORD_BYTES), PC_SPAN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC ownership, IF/ID valid/ready handoff, redirects, halt and fault.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    output logic [31:0] PcOut,
    input  logic [31:0] InstrIn,
    output logic        IfValid,
    input  logic        IfReady,
    output logic [31:0] IfInstr,
    output logic [31:0] IfPcPlus4,
    output logic        Halted,
    output logic        Fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount
`endif
);

    fetch_state_e state_d, state_q;
    if_payload_t  if_d, if_q;
    logic         if_valid_d, if_valid_q;
    logic         halted_d, halted_q;
    logic         fault_d, fault_q;
    logic         pc_redirect_c;
    logic         pc_advance_c;

    fetch_pc_reg #(
        .IMEM_WORDS (IMEM_WORDS),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk             (Clk),
        .rst_n           (Rst_n),
        .redirect        (pc_redirect_c),
        .redirect_target (RedirectTarget),
        .advance         (pc_advance_c),
        .pc              (PcOut)
    );

    // Next-state and IF/ID register update.
    always_comb begin
        state_d       = state_q;
        if_d          = if_q;
        if_valid_d    = if_valid_q;
        halted_d      = halted_q;
        fault_d       = fault_q;
        pc_redirect_c = 1'b0;
        pc_advance_c  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (RedirectValid) begin
                    // A taken redirect always flushes the held word, accepted or not.
                    if_valid_d = 1'b0;
                    if (RedirectTarget[1:0] != 2'b00) begin
                        fault_d  = 1'b1;
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end else begin
                        pc_redirect_c = 1'b1;
                    end
                end else if (!if_valid_q || IfReady) begin
                    if_d.instr    = InstrIn;
                    if_d.pc_plus4 = PcOut + 32'(WORD_BYTES);
                    if_valid_d    = 1'b1;
                    if (InstrIn == HALT_WORD) begin
                        halted_d = 1'b1;
                        state_d  = HALTED;
                    end else begin
                        pc_advance_c = 1'b1;
                    end
                end
            end
            HALTED: begin
                if (if_valid_q && IfReady) begin
                    if_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            if_q       <= '0;
            if_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_q       <= if_d;
            if_valid_q <= if_valid_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
        end
    end

    assign IfValid   = if_valid_q;
    assign IfInstr   = if_q.instr;
    assign IfPcPlus4 = if_q.pc_plus4;
    assign Halted    = halted_q;
    assign Fault     = fault_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_d, fetch_cnt_q;
    logic [31:0] stall_cnt_d, stall_cnt_q;

    // Handoff and backpressure counters; both wrap naturally at 2^32.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (if_valid_q && IfReady) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (if_valid_q && !IfReady) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign FetchCount = fetch_cnt_q;
    assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table, hand-written corner sequences,
// and randomized episodes against a behavioural model of the fetch rules.
`timescale 1ns/1ps
module tb_fetch_controller;

    localparam int unsigned IMEM_WORDS = 1024;
    localparam logic [31:0] SPAN       = 32'd4096;
    localparam logic [31:0] HALT       = 32'h0000_000C;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Start;
    logic        RedirectValid;
    logic [31:0] RedirectTarget;
    logic [31:0] PcOut;
    logic [31:0] InstrIn;
    logic        IfValid;
    logic        IfReady;
    logic [31:0] IfInstr;
    logic [31:0] IfPcPlus4;
    logic        Halted;
    logic        Fault;
`ifdef FETCH_PERF_EN
    logic [31:0] FetchCount;
    logic [31:0] StallCount;
`endif

    logic [31:0] mem [IMEM_WORDS];

    int n_vec = 0;
    int n_err = 0;

    fetch_controller #(
        .IMEM_WORDS (IMEM_WORDS),
        .RESET_PC   (32'h0000_0000),
        .HALT_WORD  (HALT)
    ) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .Start          (Start),
        .RedirectValid  (RedirectValid),
        .RedirectTarget (RedirectTarget),
        .PcOut          (PcOut),
        .InstrIn        (InstrIn),
        .IfValid        (IfValid),
        .IfReady        (IfReady),
        .IfInstr        (IfInstr),
        .IfPcPlus4      (IfPcPlus4),
        .Halted         (Halted),
        .Fault          (Fault)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount     (FetchCount),
        .StallCount     (StallCount)
`endif
    );

    always #5 Clk = ~Clk;

    assign InstrIn = mem[PcOut[11:2]];

    // Behavioural model state
    bit          m_started, m_stopped, m_valid, m_fault;
    logic [31:0] m_pc, m_instr, m_pc4, m_fcnt, m_scnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        m_started = 0; m_stopped = 0; m_valid = 0; m_fault = 0;
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_fcnt = 32'h0; m_scnt = 32'h0;
    endtask

    // One clock of the fetch rules, using the inputs currently driven.
    task automatic model_step();
        logic [31:0] w;
        if (m_valid && IfReady)  m_fcnt = m_fcnt + 1;
        if (m_valid && !IfReady) m_scnt = m_scnt + 1;
        if (!m_started) begin
            if (Start) m_started = 1;
        end else if (!m_stopped) begin
            if (RedirectValid && RedirectTarget[1:0] != 2'b00) begin
                m_valid = 0; m_fault = 1; m_stopped = 1;
            end else if (RedirectValid) begin
                m_valid = 0;
                m_pc = RedirectTarget % SPAN;
            end else if (!m_valid || IfReady) begin
                w = mem[(m_pc / 4) % IMEM_WORDS];
                m_instr = w;
                m_pc4 = m_pc + 4;
                m_valid = 1;
                if (w == HALT) m_stopped = 1;
                else m_pc = (m_pc + 4) % SPAN;
            end
        end else if (m_valid && IfReady) begin
            m_valid = 0;
        end
    endtask

    task automatic model_compare(input string tag);
        chk({tag, ".valid"}, 32'(IfValid), 32'(m_valid));
        chk({tag, ".pc"}, PcOut, m_pc);
        chk({tag, ".halted"}, 32'(Halted), 32'(m_stopped));
        chk({tag, ".fault"}, 32'(Fault), 32'(m_fault));
        if (m_valid) begin
            chk({tag, ".instr"}, IfInstr, m_instr);
            chk({tag, ".pc4"}, IfPcPlus4, m_pc4);
        end
`ifdef FETCH_PERF_EN
        chk({tag, ".fcnt"}, FetchCount, m_fcnt);
        chk({tag, ".scnt"}, StallCount, m_scnt);
`endif
    endtask

    task automatic do_reset();
        Start = 0; RedirectValid = 0; RedirectTarget = 32'h0; IfReady = 0;
        Rst_n = 0;
        model_reset();
        tick();
        Rst_n = 1;
    endtask

    task automatic fill_default_mem();
        for (int i = 0; i < int'(IMEM_WORDS); i++) mem[i] = 32'h2400_0000 | 32'(i);
        mem[0]  = 32'h2008_0001;
        mem[1]  = 32'h2009_0002;
        mem[2]  = 32'h200A_0003;
        mem[16] = 32'h8C10_0040;
        mem[17] = 32'h8C11_0044;
    endtask

    typedef struct {
        bit          start;
        bit          rv;
        logic [31:0] rt;
        bit          rdy;
        bit          e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic [31:0] e_pc;
        bit          e_halt;
        bit          e_fault;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // start, rv, rt, rdy | valid, instr, pc4, pc, halted, fault (after the edge)
        tbl[0]  = '{1, 0, 32'h0,  1, 0, 32'h0,         32'h0,  32'h0,  0, 0};
        tbl[1]  = '{0, 0, 32'h0,  1, 1, 32'h2008_0001, 32'h4,  32'h4,  0, 0};
        tbl[2]  = '{0, 0, 32'h0,  1, 1, 32'h2009_0002, 32'h8,  32'h8,  0, 0};
        tbl[3]  = '{0, 0, 32'h0,  0, 1, 32'h2009_0002, 32'h8,  32'h8,  0, 0};
        tbl[4]  = '{0, 0, 32'h0,  0, 1, 32'h2009_0002, 32'h8,  32'h8,  0, 0};
        tbl[5]  = '{0, 0, 32'h0,  0, 1, 32'h2009_0002, 32'h8,  32'h8,  0, 0};
        tbl[6]  = '{0, 0, 32'h0,  1, 1, 32'h200A_0003, 32'hC,  32'hC,  0, 0};
        tbl[7]  = '{0, 1, 32'h40, 1, 0, 32'h0,         32'h0,  32'h40, 0, 0};
        tbl[8]  = '{0, 0, 32'h0,  1, 1, 32'h8C10_0040, 32'h44, 32'h44, 0, 0};
        tbl[9]  = '{0, 0, 32'h0,  0, 1, 32'h8C10_0040, 32'h44, 32'h44, 0, 0};
        tbl[10] = '{0, 0, 32'h0,  1, 1, 32'h8C11_0044, 32'h48, 32'h48, 0, 0};
        tbl[11] = '{0, 1, 32'h42, 0, 0, 32'h0,         32'h0,  32'h48, 1, 1};
        tbl[12] = '{0, 0, 32'h0,  1, 0, 32'h0,         32'h0,  32'h48, 1, 1};
        tbl[13] = '{1, 0, 32'h0,  1, 0, 32'h0,         32'h0,  32'h48, 1, 1};

        fill_default_mem();
        do_reset();

        // Reset state
        chk("rst.valid", 32'(IfValid), 32'h0);
        chk("rst.pc", PcOut, 32'h0);
        chk("rst.instr", IfInstr, 32'h0);
        chk("rst.pc4", IfPcPlus4, 32'h0);
        chk("rst.halted", 32'(Halted), 32'h0);
        chk("rst.fault", 32'(Fault), 32'h0);
`ifdef FETCH_PERF_EN
        chk("rst.fcnt", FetchCount, 32'h0);
        chk("rst.scnt", StallCount, 32'h0);
`endif

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            Start = tbl[i].start;
            RedirectValid = tbl[i].rv;
            RedirectTarget = tbl[i].rt;
            IfReady = tbl[i].rdy;
            tick();
            chk($sformatf("tbl%0d.valid", i), 32'(IfValid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d.pc", i), PcOut, tbl[i].e_pc);
            chk($sformatf("tbl%0d.halted", i), 32'(Halted), 32'(tbl[i].e_halt));
            chk($sformatf("tbl%0d.fault", i), 32'(Fault), 32'(tbl[i].e_fault));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d.instr", i), IfInstr, tbl[i].e_instr);
                chk($sformatf("tbl%0d.pc4", i), IfPcPlus4, tbl[i].e_pc4);
            end
`ifdef FETCH_PERF_EN
            if (i == 5) begin
                chk("tbl5.scnt", StallCount, 32'd3);
                chk("tbl5.fcnt", FetchCount, 32'd1);
            end
`endif
        end

        // Halt word at 0x8: delivered, then fetch stops with PcOut parked at 0x8
        do_reset();
        mem[2] = HALT;
        Start = 1; IfReady = 1;
        tick();
        Start = 0;
        tick();
        tick();
        tick();
        chk("halt.valid", 32'(IfValid), 32'h1);
        chk("halt.instr", IfInstr, HALT);
        chk("halt.pc4", IfPcPlus4, 32'hC);
        chk("halt.pc", PcOut, 32'h8);
        chk("halt.halted", 32'(Halted), 32'h1);
        IfReady = 0;
        tick();
        chk("halt.hold_valid", 32'(IfValid), 32'h1);
        chk("halt.hold_instr", IfInstr, HALT);
        IfReady = 1;
        tick();
        chk("halt.drain_valid", 32'(IfValid), 32'h0);
        tick();
        chk("halt.after_valid", 32'(IfValid), 32'h0);
        chk("halt.after_pc", PcOut, 32'h8);
        chk("halt.after_fault", 32'(Fault), 32'h0);
        mem[2] = 32'h200A_0003;

        // PC wrap at the top of memory and modulo redirect
        do_reset();
        Start = 1; IfReady = 1;
        tick();
        Start = 0; RedirectValid = 1; RedirectTarget = 32'hFFC;
        tick();
        chk("wrap.redir_pc", PcOut, 32'hFFC);
        chk("wrap.redir_valid", 32'(IfValid), 32'h0);
        RedirectValid = 0;
        tick();
        chk("wrap.pc", PcOut, 32'h0);
        chk("wrap.instr", IfInstr, 32'h2400_03FF);
        chk("wrap.pc4", IfPcPlus4, 32'h1000);
        tick();
        chk("wrap.next_instr", IfInstr, 32'h2008_0001);
        chk("wrap.next_pc", PcOut, 32'h4);
        RedirectValid = 1; RedirectTarget = 32'h1040;
        tick();
        chk("wrap.mod_redir_pc", PcOut, 32'h40);
        RedirectValid = 0;

        // Asynchronous reset in the middle of a stall
        do_reset();
        Start = 1; IfReady = 0;
        tick();
        Start = 0;
        tick();
        tick();
        chk("arst.pre_valid", 32'(IfValid), 32'h1);
        #3;
        Rst_n = 0;
        #1;
        chk("arst.valid", 32'(IfValid), 32'h0);
        chk("arst.pc", PcOut, 32'h0);
        chk("arst.instr", IfInstr, 32'h0);
        chk("arst.pc4", IfPcPlus4, 32'h0);
        chk("arst.halted", 32'(Halted), 32'h0);
`ifdef FETCH_PERF_EN
        chk("arst.scnt", StallCount, 32'h0);
`endif
        tick();
        Rst_n = 1;
        tick();
        chk("arst.idle_valid", 32'(IfValid), 32'h0);
        chk("arst.idle_pc", PcOut, 32'h0);

        // Randomized episodes against the behavioural model
        for (int ep = 0; ep < 20; ep++) begin
            for (int i = 0; i < int'(IMEM_WORDS); i++) begin
                mem[i] = ($urandom_range(0, 59) == 0) ? HALT : $urandom;
            end
            do_reset();
            model_compare($sformatf("rnd%0d.rst", ep));
            for (int c = 0; c < 200; c++) begin
                Start = ($urandom_range(0, 3) == 0);
                RedirectValid = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 19) == 0) begin
                    RedirectTarget = $urandom;
                    RedirectTarget[1:0] = 2'($urandom_range(1, 3));
                end else begin
                    RedirectTarget = {19'h0, 11'($urandom_range(0, 2047)), 2'b00};
                end
                IfReady = ($urandom_range(0, 9) < 7);
                model_step();
                tick();
                model_compare($sformatf("rnd%0d.c%0d", ep, c));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the combinational instruction memory for the MIPS datapath. Owns the program counter, drives the byte address into instruction memory, registers the returned word, and hands it to the IF/ID stage over a valid/ready handshake. Also handles branch/jump redirects, halt detection, and misaligned-target faults.

## Interface
Parameters:
- IMEM_WORDS, 1024: instruction memory depth in words; PC wraps modulo IMEM_WORDS*4.
- RESET_PC, 32'h0000_0000: PC loaded at reset.
- HALT_WORD, 32'h0000_000C: encoding (syscall) that ends fetch.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Start  in  1  leave IDLE and begin fetching.
- RedirectValid  in  1  branch/jump taken this cycle.
- RedirectTarget  in  32  byte address of the redirect.
- PcOut  out  32  byte address to instruction memory (registered).
- InstrIn  in  32  word returned combinationally by instruction memory for PcOut.
- IfValid  out  1  IfInstr/IfPcPlus4 hold a valid fetch.
- IfReady  in  1  downstream accepts when IfValid && IfReady.
- IfInstr  out  32  fetched instruction.
- IfPcPlus4  out  32  address of IfInstr + 4.
- Halted  out  1  fetch stopped.
- Fault  out  1  stopped on a misaligned redirect.

## Operation
- States: IDLE, FETCH, HALTED. Reset puts the block in IDLE with PcOut=RESET_PC and IfValid, IfInstr, IfPcPlus4, Halted, and Fault all 0.
- IDLE: if Start=1, go to FETCH next cycle. Redirects are ignored.
- FETCH, per cycle, in priority order:
  1. RedirectValid=1 with RedirectTarget[1:0]!=0: IfValid<=0, Fault<=1, go to HALTED.
  2. RedirectValid=1, aligned target: IfValid<=0 (the registered word is flushed even if accepted this cycle), PcOut<=RedirectTarget mod (IMEM_WORDS*4).
  3. Load slot free (!IfValid || IfReady): IfInstr<=InstrIn, IfPcPlus4<=PcOut+4, IfValid<=1, PcOut<=(PcOut+4) mod (IMEM_WORDS*4). If InstrIn==HALT_WORD, the halt word is still loaded and the state goes to HALTED; PcOut does not advance.
  4. Otherwise (stall): hold all registers.
- HALTED: Halted=1, no new loads. A pending IfValid word still drains on IfReady, after which IfValid<=0. Leave only by reset.
- PC arithmetic is 32-bit. Wrap: PcOut=IMEM_WORDS*4-4 advances to 0. IfPcPlus4 is not wrapped.

## Timing
- Fetch latency: the word at PcOut appears on IfInstr with IfValid=1 one cycle after the edge that set PcOut.
- Start asserted in cycle N puts the block in FETCH at N+1; the first IfValid=1 is at N+2.
- Throughput: one instruction per cycle while IfReady=1. Redirect bubble: one cycle.
- IfInstr/IfPcPlus4 are stable while IfValid && !IfReady.
- Rst_n low at any time, mid-stall or mid-redirect included, immediately returns to the reset values.

## Configuration
- FETCH_PERF_EN defined: adds outputs FetchCount[31:0] (increments on each IfValid&&IfReady) and StallCount[31:0] (increments on each cycle with IfValid&&!IfReady). Both reset to 0 and wrap at 2^32.
- FETCH_PERF_EN undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package fetch_pkg: state encoding (IDLE=2'd0, FETCH=2'd1, HALTED=2'd2), HALT_WORD default, and the word-size constant 4.
- One sub-module, fetch_pc_reg: the PC register with wrap and redirect mux.
- Instruction memory stays external.

## Test plan
- Reset, then Start=1 with IfReady=1 and memory holding words 0x20080001, 0x20090002: IfInstr=0x20080001, IfPcPlus4=4 at cycle 2, then 0x20090002, IfPcPlus4=8 at cycle 3.
- IfReady=0 for 3 cycles with IfValid=1: IfInstr is held and PcOut is unchanged; with FETCH_PERF_EN, StallCount=3.
- RedirectValid=1, target 0x40, while a word is valid: the next cycle has IfValid=0 and PcOut=0x40, and the word at 0x40 follows one cycle later.
- Redirect to 0x42: Fault=1 and Halted=1 next cycle, with no further IfValid.
- Word 0x0000000C at address 0x8: delivered with IfPcPlus4=0xC, then Halted=1 and PcOut stays at 0x8.
- PcOut=0xFFC with IMEM_WORDS=1024: the next PcOut is 0; Rst_n pulsed low during a stall clears IfValid immediately.
